fetch_ctrl: RTL and testbench



---
 rtl/fetch_ctrl_pkg.sv | 19 +
 rtl/pc_next_sel.sv | 29 ++
 rtl/fetch_ctrl.sv | 115 +++++++++++
 tb/tb_fetch_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch stage: parameter defaults, enable levels
// and the fetch sequencer state encoding.
package fetch_ctrl_pkg;

  localparam int unsigned DEF_PC_LENGTH = 32;
  localparam int unsigned DEF_PC_STEP   = 4;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    FC_IDLE  = 2'd0,
    FC_FETCH = 2'd1,
    FC_WAIT  = 2'd2,
    FC_STALL = 2'd3
  } fc_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next program counter selection for the fetch stage.
//   pc       : current fetch address
//   target   : redirect destination (already word aligned)
//   redirect : take the redirect target this cycle
//   advance  : sequential advance by PC_STEP this cycle
//   pc_next  : selected next fetch address (pc when neither is asserted)
module pc_next_sel #(
  parameter int unsigned PC_LENGTH = 32,
  parameter int unsigned PC_STEP   = 4
) (
  input  logic [PC_LENGTH-1:0] pc,
  input  logic [PC_LENGTH-1:0] target,
  input  logic                 redirect,
  input  logic                 advance,
  output logic [PC_LENGTH-1:0] pc_next
);

  localparam logic [PC_LENGTH-1:0] STEP = PC_LENGTH'(PC_STEP);

  always_comb begin
    pc_next = pc;
    if (redirect) begin
      pc_next = target;
    end else if (advance) begin
      pc_next = pc + STEP;  // wraps modulo 2^PC_LENGTH
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the program counter and the InstMem chip
// enable, choosing each cycle between sequential advance, branch redirect,
// pipeline stall and waiting on a slow instruction memory.
//   clk       : system clock, rising edge
//   rst       : asynchronous active-low reset
//   stall_req : hold the fetch stage (hazard unit)
//   br_flag   : redirect fetch, one-cycle pulse (ID stage)
//   br_addr   : redirect target, low two bits ignored
//   rom_ready : InstMem word at pc is valid this cycle
//   pc        : fetch address to InstMem
//   romCe     : InstMem chip enable
//   if_valid  : IF/ID captures the word fetched at the previous pc
//   flush     : IF/ID kill, one-cycle pulse per applied redirect
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned          PC_LENGTH = DEF_PC_LENGTH,
  parameter int unsigned          PC_STEP   = DEF_PC_STEP,
  parameter logic [PC_LENGTH-1:0] RESET_PC  = PC_LENGTH'(DEF_RESET_PC)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_req,
  input  logic                 br_flag,
  input  logic [PC_LENGTH-1:0] br_addr,
  input  logic                 rom_ready,
  output logic [PC_LENGTH-1:0] pc,
  output logic                 romCe,
  output logic                 if_valid,
  output logic                 flush
);

  localparam logic [PC_LENGTH-1:0] ALIGN_MASK = ~PC_LENGTH'(3);

  fc_state_e             state;
  logic                  pend;
  logic [PC_LENGTH-1:0]  pend_addr;

  logic                  fetching;
  logic                  accept;
  logic                  redirect;
  logic                  advance;
  logic [PC_LENGTH-1:0]  br_aligned;
  logic [PC_LENGTH-1:0]  target;
  logic [PC_LENGTH-1:0]  pc_next;

  assign fetching   = (state == FC_FETCH) || (state == FC_WAIT);
  assign accept     = fetching && rom_ready && !stall_req;
  assign redirect   = accept && (br_flag || pend);
  assign advance    = accept && !(br_flag || pend);
  assign br_aligned = br_addr & ALIGN_MASK;
  // A fresh branch overrides one parked while memory was busy.
  assign target     = br_flag ? br_aligned : pend_addr;

  pc_next_sel #(
    .PC_LENGTH (PC_LENGTH),
    .PC_STEP   (PC_STEP)
  ) u_pc_next_sel (
    .pc       (pc),
    .target   (target),
    .redirect (redirect),
    .advance  (advance),
    .pc_next  (pc_next)
  );

  // pc loads pc_next on every edge; the selector returns pc unchanged on any
  // edge that neither redirects nor advances, so the hold cases need no
  // per-state pc assignment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RESET_PC;
      romCe     <= DISABLE;
      if_valid  <= DISABLE;
      flush     <= DISABLE;
      pend      <= 1'b0;
      pend_addr <= '0;
      state     <= FC_IDLE;
    end else begin
      pc       <= pc_next;
      if_valid <= DISABLE;
      flush    <= DISABLE;
      case (state)
        FC_IDLE: begin
          romCe <= ENABLE;
          state <= FC_FETCH;
        end
        FC_FETCH, FC_WAIT: begin
          if (!rom_ready) begin
            state <= FC_WAIT;
            if (br_flag) begin
              pend      <= 1'b1;
              pend_addr <= br_aligned;
            end
          end else if (stall_req) begin
            state <= FC_STALL;
          end else if (br_flag || pend) begin
            flush <= ENABLE;
            pend  <= 1'b0;
            state <= FC_FETCH;
          end else begin
            if_valid <= ENABLE;
            state    <= FC_FETCH;
          end
        end
        FC_STALL: begin
          if (!stall_req) begin
            state <= FC_FETCH;
          end
        end
        default: state <= FC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_req = 1'b0;
  logic        br_flag = 1'b0;
  logic [31:0] br_addr = '0;
  logic        rom_ready = 1'b1;
  logic [31:0] pc;
  logic        romCe;
  logic        if_valid;
  logic        flush;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_ctrl #(
    .PC_LENGTH (32),
    .PC_STEP   (4),
    .RESET_PC  (32'h0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall_req (stall_req),
    .br_flag   (br_flag),
    .br_addr   (br_addr),
    .rom_ready (rom_ready),
    .pc        (pc),
    .romCe     (romCe),
    .if_valid  (if_valid),
    .flush     (flush)
  );

  always #5 clk = ~clk;

  // Behavioural model: what the fetch stage must show after each edge.
  // FETCH and WAIT behave identically, so the model only tracks whether
  // fetching has started, whether it is stalled, and any parked redirect.
  logic [31:0] m_pc = '0;
  logic        m_ce = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_flush = 1'b0;
  logic        m_stalled = 1'b0;
  logic        m_pend = 1'b0;
  logic [31:0] m_pend_addr = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc = 32'h0; m_ce = 1'b0; m_valid = 1'b0; m_flush = 1'b0;
      m_stalled = 1'b0; m_pend = 1'b0; m_pend_addr = '0;
    end else begin
      m_valid = 1'b0;
      m_flush = 1'b0;
      if (!m_ce) begin
        m_ce = 1'b1;
      end else if (m_stalled) begin
        if (!stall_req) m_stalled = 1'b0;
      end else if (!rom_ready) begin
        if (br_flag) begin
          m_pend = 1'b1;
          m_pend_addr = {br_addr[31:2], 2'b00};
        end
      end else if (stall_req) begin
        m_stalled = 1'b1;
      end else if (br_flag) begin
        m_pc = {br_addr[31:2], 2'b00};
        m_flush = 1'b1;
        m_pend = 1'b0;
      end else if (m_pend) begin
        m_pc = m_pend_addr;
        m_flush = 1'b1;
        m_pend = 1'b0;
      end else begin
        m_pc = m_pc + 32'd4;
        m_valid = 1'b1;
      end
    end
  end

  // Cycle compare against the model on the falling edge.
  always @(negedge clk) begin
    n_cmp++;
    if (pc !== m_pc || romCe !== m_ce || if_valid !== m_valid || flush !== m_flush) begin
      n_bad++;
      $display("FAIL cycle t=%0t: got pc=%h ce=%b valid=%b flush=%b, want pc=%h ce=%b valid=%b flush=%b",
               $time, pc, romCe, if_valid, flush, m_pc, m_ce, m_valid, m_flush);
    end
    n_cmp++;
    if (flush === 1'b1 && if_valid === 1'b1) begin
      n_bad++;
      $display("FAIL flush_valid_excl t=%0t: got flush=1 valid=1, want not both", $time);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic jump(input logic [31:0] a);
    br_flag = 1'b1; br_addr = a;
    tick(1);
    br_flag = 1'b0;
  endtask

  initial begin
    tick(2);
    chk("rst_pc", pc, 32'h0);
    chk("rst_ce", {31'd0, romCe}, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);

    // Reset release: first fetch at 0, then sequential.
    rst = 1'b1;
    tick(1);
    chk("rel_ce", {31'd0, romCe}, 32'd1);
    chk("rel_pc", pc, 32'h0);
    tick(1);
    chk("seq_pc4", pc, 32'h4);
    chk("seq_valid4", {31'd0, if_valid}, 32'd1);
    tick(1);
    chk("seq_pc8", pc, 32'h8);

    // Branch at 0x8 to 0x43 (aligned to 0x40).
    jump(32'h43);
    chk("br_pc", pc, 32'h40);
    chk("br_flush", {31'd0, flush}, 32'd1);
    chk("br_valid", {31'd0, if_valid}, 32'd0);
    tick(1);
    chk("br_next_pc", pc, 32'h44);
    chk("br_next_valid", {31'd0, if_valid}, 32'd1);
    chk("br_next_flush", {31'd0, flush}, 32'd0);

    // Slow memory at 0x10 with a branch parked in the 2nd wait cycle.
    jump(32'h12);
    chk("jmp10_pc", pc, 32'h10);
    rom_ready = 1'b0;
    tick(1);
    br_flag = 1'b1; br_addr = 32'h100;
    tick(1);
    br_flag = 1'b0;
    chk("wait_pc", pc, 32'h10);
    chk("wait_flush", {31'd0, flush}, 32'd0);
    tick(1);
    chk("wait3_valid", {31'd0, if_valid}, 32'd0);
    rom_ready = 1'b1;
    tick(1);
    chk("pend_pc", pc, 32'h100);
    chk("pend_flush", {31'd0, flush}, 32'd1);
    tick(1);
    chk("pend_next_pc", pc, 32'h104);

    // Parked redirect loses to a fresh branch on the accepting edge.
    rom_ready = 1'b0;
    br_flag = 1'b1; br_addr = 32'h500;
    tick(1);
    br_flag = 1'b0;
    rom_ready = 1'b1;
    jump(32'h600);
    chk("br_over_pend_pc", pc, 32'h600);
    tick(1);
    chk("br_over_pend_next", pc, 32'h604);

    // Stall at 0x20, branch during stall ignored.
    jump(32'h20);
    stall_req = 1'b1;
    tick(1);
    chk("stall_pc", pc, 32'h20);
    br_flag = 1'b1; br_addr = 32'h200;
    tick(1);
    br_flag = 1'b0;
    chk("stall2_pc", pc, 32'h20);
    chk("stall2_flush", {31'd0, flush}, 32'd0);
    stall_req = 1'b0;
    tick(1);
    chk("unstall_pc", pc, 32'h20);
    tick(1);
    chk("after_stall_pc", pc, 32'h24);
    chk("after_stall_valid", {31'd0, if_valid}, 32'd1);

    // Async reset mid-WAIT with a pending redirect.
    rom_ready = 1'b0;
    tick(1);
    br_flag = 1'b1; br_addr = 32'h300;
    tick(1);
    br_flag = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_ce", {31'd0, romCe}, 32'd0);
    tick(1);
    rst = 1'b1;
    rom_ready = 1'b1;
    tick(1);
    chk("rerel_ce", {31'd0, romCe}, 32'd1);
    chk("rerel_pc", pc, 32'h0);
    tick(1);
    chk("rerel_pc4", pc, 32'h4);
    chk("rerel_noflush", {31'd0, flush}, 32'd0);

    // Wrap at the top of the address space.
    jump(32'hFFFF_FFFF);
    chk("wrap_top_pc", pc, 32'hFFFF_FFFC);
    tick(1);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_valid", {31'd0, if_valid}, 32'd1);

    tick(2);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
